// File: rtl/idli_sqi_ctrl_m.sv
// SQI memory transaction sequencer: CMD, 24b ADDR, optional DUMMY and DATA phases locked to the 4-cycle group counter.
// Build option: define IDLI_SQI_DUMMY_EN to insert 4 dummy cycles ahead of read data.
//
//   state | meaning
//   IDLE  | CS high, waiting for a request on the last cycle of a group
//   CMD   | 2 nibbles of command byte (0x02 write, 0x03 read)
//   ADDR  | 6 nibbles of {8'h00, addr}, most significant first
//   DUMMY | 4 turnaround cycles before read data (IDLI_SQI_DUMMY_EN only)
//   DATA  | one nibble per cycle to/from the reversing buffer until stop on group end
module idli_sqi_ctrl_m (
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst_n,
    input  logic [1:0]  i_sqi_ctr,
    input  logic        i_sqi_req,
    input  logic        i_sqi_wr,
    input  logic [15:0] i_sqi_addr,
    input  logic        i_sqi_stop,
    output logic        o_sqi_ack,
    output logic        o_sqi_busy,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_oe,
    output logic [3:0]  o_sqi_sio,
    input  logic [3:0]  i_sqi_sio,
    output logic        o_sqi_push,
    output logic [3:0]  o_sqi_slice,
    input  logic [3:0]  i_sqi_slice
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
`ifdef IDLI_SQI_DUMMY_EN
        S_DUMMY = 3'd3,
`endif
        S_DATA  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic        arm_q;

    logic        last_group;
    logic        cnt_zero;
    logic        accept;
    logic [23:0] addr_word;

    assign last_group = (i_sqi_ctr == 2'd3);
    assign cnt_zero   = (cnt_q == 3'd0);
    assign addr_word  = {8'h00, addr_q};
    // arm_q blocks acceptance until one edge after reset release
    assign accept     = (state_q == S_IDLE) && i_sqi_req && last_group && arm_q;

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0000;
            wr_q    <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            arm_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CMD;
                    cnt_d   = 3'd1;
                    addr_d  = i_sqi_addr;
                    wr_d    = i_sqi_wr;
                end
            end
            S_CMD: begin
                if (cnt_zero) begin
                    state_d = S_ADDR;
                    cnt_d   = 3'd5;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ADDR: begin
                if (cnt_zero) begin
`ifdef IDLI_SQI_DUMMY_EN
                    if (!wr_q) begin
                        state_d = S_DUMMY;
                        cnt_d   = 3'd3;
                    end else begin
                        state_d = S_DATA;
                    end
`else
                    state_d = S_DATA;
`endif
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef IDLI_SQI_DUMMY_EN
            S_DUMMY: begin
                if (cnt_zero) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`endif
            S_DATA: begin
                // stop only counts on a group boundary so whole words are moved
                if (i_sqi_stop && last_group) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_sqi_ack   = accept;
        o_sqi_busy  = 1'b1;
        o_sqi_cs_n  = 1'b1;
        o_sqi_oe    = 1'b0;
        o_sqi_sio   = 4'h0;
        o_sqi_push  = 1'b0;
        o_sqi_slice = 4'h0;
        case (state_q)
            S_IDLE: begin
                o_sqi_busy = 1'b0;
            end
            S_CMD: begin
                o_sqi_cs_n = 1'b0;
                o_sqi_oe   = 1'b1;
                o_sqi_sio  = cnt_q[0] ? 4'h0 : {3'b001, ~wr_q};
            end
            S_ADDR: begin
                o_sqi_cs_n = 1'b0;
                o_sqi_oe   = 1'b1;
                o_sqi_sio  = addr_word[{cnt_q, 2'b00} +: 4];
            end
`ifdef IDLI_SQI_DUMMY_EN
            S_DUMMY: begin
                o_sqi_cs_n = 1'b0;
            end
`endif
            S_DATA: begin
                o_sqi_cs_n = 1'b0;
                o_sqi_push = 1'b1;
                if (wr_q) begin
                    o_sqi_oe  = 1'b1;
                    o_sqi_sio = i_sqi_slice;
                end else begin
                    o_sqi_slice = i_sqi_sio;
                end
            end
            default: begin
                o_sqi_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/idli_sqi_ctrl_m.md
IDLI_SQI_CTRL_M -- requirements
Module: idli_sqi_ctrl_m

Interface
REQ-001 SHALL provide i_sqi_gck, input, 1b: single block clock; all state updates on its rising edge.
REQ-002 SHALL provide i_sqi_rst_n, input, 1b: reset, asynchronous assert, active-low.
REQ-003 SHALL provide i_sqi_ctr, input, ctr_t: global 4-GCK phase counter; value 3 marks the last cycle of a 4-cycle group.
REQ-004 SHALL provide i_sqi_req, input, 1b: upstream request for a memory transaction; held until o_sqi_ack.
REQ-005 SHALL provide i_sqi_wr, input, 1b: 1 = write transaction, 0 = read transaction; valid with i_sqi_req.
REQ-006 SHALL provide i_sqi_addr, input, data_t: 16b word address; valid with i_sqi_req.
REQ-007 SHALL provide i_sqi_stop, input, 1b: ends the DATA phase at the next group boundary.
REQ-008 SHALL provide o_sqi_ack, output, 1b: one-cycle pulse on request acceptance.
REQ-009 SHALL provide o_sqi_busy, output, 1b: high whenever state is not IDLE.
REQ-010 SHALL provide o_sqi_cs_n, output, 1b: memory chip select, active-low.
REQ-011 SHALL provide o_sqi_oe, output, 1b: 1 = block drives memory SIO pins.
REQ-012 SHALL provide o_sqi_sio, output, slice_t: nibble driven to memory SIO pins.
REQ-013 SHALL provide i_sqi_sio, input, slice_t: nibble sampled from memory SIO pins.
REQ-014 SHALL provide o_sqi_push, output, 1b: push strobe to the downstream 16b reversing buffer.
REQ-015 SHALL provide o_sqi_slice, output, slice_t: write nibble into the buffer (read data from memory).
REQ-016 SHALL provide i_sqi_slice, input, slice_t: current buffer slice (write data to memory).

Function
REQ-017 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA.
REQ-018 SHALL accept a request only in IDLE with i_sqi_req=1 and i_sqi_ctr=3; o_sqi_ack=1 that cycle; address and direction captured.
REQ-019 SHALL transition IDLE->CMD on acceptance; CMD lasts 2 cycles, driving 0x02 (write) or 0x03 (read), high nibble first.
REQ-020 SHALL follow CMD with ADDR lasting 6 cycles, driving 24b address {8'h00, addr} most significant nibble first.
REQ-021 SHALL, for reads, enter DUMMY after ADDR when dummy cycles are enabled (REQ-032), else enter DATA directly; writes always enter DATA directly.
REQ-022 SHALL hold o_sqi_cs_n=0 in CMD, ADDR, DUMMY and DATA, and 1 in IDLE.
REQ-023 SHALL drive o_sqi_oe=1 in CMD, ADDR and write DATA; 0 in IDLE, DUMMY and read DATA.
REQ-024 SHALL in DATA assert o_sqi_push every cycle; reads: o_sqi_slice=i_sqi_sio same cycle; writes: o_sqi_sio=i_sqi_slice same cycle.
REQ-025 SHALL hold o_sqi_push=0 outside DATA; DATA SHALL always start at i_sqi_ctr=0.
REQ-026 SHALL leave DATA for IDLE only when i_sqi_stop=1 and i_sqi_ctr=3; i_sqi_stop at other phases is ignored, so DATA length is a multiple of 4 cycles (whole 16b words).
REQ-027 SHALL not accept a new request in the cycle DATA exits; minimum CS high time is therefore 4 cycles.
REQ-028 SHALL drive o_sqi_sio=0 whenever o_sqi_oe=0 and o_sqi_slice=0 outside read DATA.
REQ-029 SHALL ignore i_sqi_req, i_sqi_wr and i_sqi_addr changes while busy.

Reset
REQ-030 SHALL on i_sqi_rst_n=0, immediately and at any state: state=IDLE, o_sqi_cs_n=1, o_sqi_oe=0, o_sqi_push=0, o_sqi_ack=0, o_sqi_busy=0, o_sqi_sio=0, o_sqi_slice=0, internal cycle counter=0.
REQ-031 SHALL after reset release accept requests only from the next i_sqi_ctr=3.

Configuration
REQ-032 SHALL, with IDLI_SQI_DUMMY_EN defined, insert DUMMY of 4 cycles on reads (oe=0, push=0), keeping DATA aligned to i_sqi_ctr=0; without it, DUMMY state is removed and reads go ADDR->DATA.

Verification
REQ-033 SHALL cover: read req at addr 0x1234, ctr=3 -> ack pulse; sio 0,3,0,0,1,2,3,4; push from first ctr=0 after ADDR (or DUMMY).
REQ-034 SHALL cover: write addr 0xBEEF, buffer slices A,B,C,D, stop at ctr=3 -> sio 0,2,0,0,B,E,E,F then A,B,C,D with oe=1; cs_n=1 next cycle.
REQ-035 SHALL cover: req asserted at ctr=1 -> no ack until ctr=3; cs_n stays 1 meanwhile.
REQ-036 SHALL cover: stop pulsed at ctr=1 only -> DATA continues; stop held through ctr=3 of third group -> exactly 12 pushes.
REQ-037 SHALL cover: rst_n low mid-ADDR -> cs_n=1, oe=0, busy=0 same cycle without clock edge; next req accepted normally.
REQ-038 SHALL cover: back-to-back reqs -> second ack no earlier than 4 cycles after first DATA exit.
